// File: rtl/per2axi_res_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// per2axi_res_sched : round-robin R/B response scheduler for the per2axi bridge
// Optional per-entry watchdog: define PER2AXI_RES_SCHED_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module per2axi_res_sched #(
  parameter int NB_CORES       = 4,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      trans_gnt_o,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  output logic                      axi_master_r_ready_o,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  output logic                      axi_master_b_ready_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [NB_CORES-1:0]       axi_xresp_valid_o,
  output logic [NB_CORES-1:0]       axi_xresp_slverr_o,
  output logic                      unexpected_o,
  output logic                      busy_o
);

  localparam int NUM_IDS = 2 ** AXI_ID_WIDTH;

  typedef enum logic [0:0] {
    PRIO_R = 1'b0,
    PRIO_B = 1'b1
  } arb_state_e;

  arb_state_e state_q, state_d;

  logic [NUM_IDS-1:0] pending_q, we_buf_q, lane_buf_q;
  logic [NUM_IDS-1:0] core_mask, alloc_vec, retire_vec;

  logic                    grant_r, grant_b, any_grant;
  logic [AXI_ID_WIDTH-1:0] hs_id;
  logic [1:0]              hs_resp;
  logic                    hs_match, fwd, retire, alloc;
  logic                    to_fire;
  logic [AXI_ID_WIDTH-1:0] to_id;

  logic                    rsp_valid_d, rsp_opc_d;
  logic [PER_ID_WIDTH-1:0] rsp_id_d;
  logic [31:0]             rsp_rdata_d;
  logic [NB_CORES-1:0]     rsp_xerr_d;

  function automatic logic [PER_ID_WIDTH-1:0] per_onehot(input logic [AXI_ID_WIDTH-1:0] id);
    per_onehot = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++) per_onehot[i] = (int'(id) == i);
  endfunction

  function automatic logic [NB_CORES-1:0] core_onehot(input logic [AXI_ID_WIDTH-1:0] id);
    core_onehot = '0;
    for (int i = 0; i < NB_CORES; i++) core_onehot[i] = (int'(id) == i);
  endfunction

  // IDs beyond NB_CORES have no requester and never allocate an entry
  for (genvar g = 0; g < NUM_IDS; g++) begin : g_core_mask
    assign core_mask[g] = (g < NB_CORES);
  end

  assign trans_gnt_o = ~pending_q[trans_id_i];
  assign alloc       = trans_req_i & trans_gnt_o & core_mask[trans_id_i];
  assign alloc_vec   = alloc ? (NUM_IDS'(1) << trans_id_i) : '0;
  assign busy_o      = |pending_q;

  // Arbitration FSM: next-state and grant outputs
  always_comb begin
    state_d = state_q;
    grant_r = axi_master_r_valid_i & (~axi_master_b_valid_i | (state_q == PRIO_R));
    grant_b = axi_master_b_valid_i & ~grant_r;
    if (grant_r) begin
      state_d = PRIO_B;
    end else if (grant_b) begin
      state_d = PRIO_R;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= PRIO_R;
    else         state_q <= state_d;
  end

  assign axi_master_r_ready_o = grant_r;
  assign axi_master_b_ready_o = grant_b;

  always_comb begin
    any_grant = grant_r | grant_b;
    hs_id     = grant_r ? axi_master_r_id_i : axi_master_b_id_i;
    hs_resp   = grant_r ? axi_master_r_resp_i : axi_master_b_resp_i;
    // we_buf says which channel the entry expects: 1 = B, 0 = R
    hs_match  = pending_q[hs_id] & (we_buf_q[hs_id] == grant_b);
    fwd       = any_grant & hs_match;
    retire    = fwd & (grant_b | axi_master_r_last_i);
  end

`ifdef PER2AXI_RES_SCHED_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]   cnt_q [NUM_IDS];
  logic [NUM_IDS-1:0] expired;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (alloc_vec[i]) begin
          cnt_q[i] <= '0;
        end else if (pending_q[i] && (cnt_q[i] != CNT_LIMIT)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest expired ID wins; any AXI grant pre-empts the synthesized response
  always_comb begin
    to_id = '0;
    for (int i = 0; i < NUM_IDS; i++) expired[i] = pending_q[i] & (cnt_q[i] == CNT_LIMIT);
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (expired[i]) to_id = AXI_ID_WIDTH'(i);
    end
    to_fire = (|expired) & ~any_grant;
  end
`else
  assign to_fire = 1'b0;
  assign to_id   = '0;
`endif

  assign retire_vec = (retire  ? (NUM_IDS'(1) << hs_id) : '0)
                    | (to_fire ? (NUM_IDS'(1) << to_id) : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      we_buf_q   <= '0;
      lane_buf_q <= '0;
    end else begin
      pending_q  <= (pending_q | alloc_vec) & ~retire_vec;
      we_buf_q   <= (we_buf_q & ~alloc_vec) | (alloc_vec & {NUM_IDS{trans_we_i}});
      lane_buf_q <= (lane_buf_q & ~alloc_vec) | (alloc_vec & {NUM_IDS{trans_add_i[2]}});
    end
  end

  always_comb begin
    rsp_valid_d = fwd | to_fire;
    rsp_opc_d   = 1'b0;
    rsp_id_d    = '0;
    rsp_rdata_d = '0;
    rsp_xerr_d  = '0;
    if (fwd) begin
      rsp_opc_d = hs_resp[1];
      rsp_id_d  = per_onehot(hs_id);
      if (grant_r) begin
        rsp_rdata_d = lane_buf_q[hs_id] ? axi_master_r_data_i[63:32] : axi_master_r_data_i[31:0];
      end else begin
        rsp_rdata_d = {31'b0, ~axi_master_b_resp_i[1]};
      end
      if (hs_resp == 2'b10) rsp_xerr_d = core_onehot(hs_id);
    end else if (to_fire) begin
      rsp_opc_d  = 1'b1;
      rsp_id_d   = per_onehot(to_id);
      rsp_xerr_d = core_onehot(to_id);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_slave_r_valid_o <= 1'b0;
      per_slave_r_opc_o   <= 1'b0;
      per_slave_r_id_o    <= '0;
      per_slave_r_rdata_o <= '0;
      axi_xresp_valid_o   <= '0;
      axi_xresp_slverr_o  <= '0;
      unexpected_o        <= 1'b0;
    end else begin
      per_slave_r_valid_o <= rsp_valid_d;
      per_slave_r_opc_o   <= rsp_opc_d;
      per_slave_r_id_o    <= rsp_id_d;
      per_slave_r_rdata_o <= rsp_rdata_d;
      axi_xresp_valid_o   <= rsp_xerr_d;
      axi_xresp_slverr_o  <= rsp_xerr_d;
      unexpected_o        <= unexpected_o | (any_grant & ~hs_match);
    end
  end

  logic unused;
  assign unused = ^{trans_add_i, 1'(TIMEOUT_CYCLES)};

endmodule
`default_nettype wire

// File: tb/tb_per2axi_res_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_per2axi_res_sched : directed scenarios plus randomized run vs. a reference model
// ----------------------------------------------------------------------------
module tb_per2axi_res_sched;

  localparam int NB_CORES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trans_req, trans_we, trans_gnt;
  logic [2:0]  trans_id;
  logic [31:0] trans_add;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [2:0]  r_id;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic        per_valid, per_opc, unexp, busy;
  logic [4:0]  per_id;
  logic [31:0] per_rdata;
  logic [3:0]  xv, xs;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  per2axi_res_sched #(
    .NB_CORES(4), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .trans_req_i(trans_req), .trans_we_i(trans_we), .trans_id_i(trans_id),
    .trans_add_i(trans_add), .trans_gnt_o(trans_gnt),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
    .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
    .axi_master_r_id_i(r_id), .axi_master_r_ready_o(r_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
    .axi_master_b_id_i(b_id), .axi_master_b_ready_o(b_ready),
    .per_slave_r_valid_o(per_valid), .per_slave_r_opc_o(per_opc),
    .per_slave_r_id_o(per_id), .per_slave_r_rdata_o(per_rdata),
    .axi_xresp_valid_o(xv), .axi_xresp_slverr_o(xs),
    .unexpected_o(unexp), .busy_o(busy)
  );

  // Reference model: outstanding-transaction table and who was served last
  bit [7:0] m_pend, m_we, m_lane;
  bit       m_last_was_r, m_unexp;
  logic     e_rr, e_br, e_gnt, e_valid, e_opc;
  logic [4:0]  e_id;
  logic [31:0] e_rdata;
  logic [3:0]  e_xv;
  bit       n_retire, n_unexp;
  int       n_retire_id;

  task automatic idle();
    trans_req = 0; trans_we = 0; trans_id = 0; trans_add = 0;
    r_valid = 0; r_data = 0; r_resp = 0; r_last = 0; r_id = 0;
    b_valid = 0; b_resp = 0; b_id = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic model_reset();
    m_pend = '0; m_we = '0; m_lane = '0; m_last_was_r = 0; m_unexp = 0;
  endtask

  task automatic predict();
    bit gr, gb, ok;
    int id;
    logic [1:0] resp;
    gr = r_valid && (!b_valid || !m_last_was_r);
    gb = b_valid && !gr;
    e_rr = gr; e_br = gb;
    e_gnt = !m_pend[trans_id];
    e_valid = 0; e_opc = 0; e_id = 0; e_rdata = 0; e_xv = 0;
    n_retire = 0; n_unexp = 0; n_retire_id = 0;
    if (gr || gb) begin
      id   = gr ? int'(r_id) : int'(b_id);
      resp = gr ? r_resp : b_resp;
      ok   = m_pend[id] && (m_we[id] == gb);
      if (ok) begin
        e_valid = 1;
        e_opc   = resp[1];
        e_id    = 5'(1 << id);
        e_rdata = gr ? (m_lane[id] ? r_data[63:32] : r_data[31:0]) : {31'b0, !resp[1]};
        if (resp == 2'b10) e_xv = 4'(1 << id);
      end
      n_retire    = ok && (gb || r_last);
      n_retire_id = id;
      n_unexp     = !ok;
    end
  endtask

  task automatic commit();
    bit alloc;
    int aid;
    alloc = trans_req && !m_pend[trans_id];
    aid   = int'(trans_id);
    @(posedge clk);
    if (n_retire) m_pend[n_retire_id] = 0;
    if (n_unexp) m_unexp = 1;
    if (e_rr) m_last_was_r = 1;
    else if (e_br) m_last_was_r = 0;
    if (alloc) begin
      m_pend[aid] = 1; m_we[aid] = trans_we; m_lane[aid] = trans_add[2];
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({per_valid, per_opc, per_id, per_rdata, xv, xs, unexp, busy, r_ready, b_ready} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h required 0",
               {per_valid, per_opc, per_id, per_rdata, xv, xs, unexp, busy, r_ready, b_ready});
    end
    nvec++;
    if (trans_gnt !== 1'b1) begin nfail++; $display("FAIL reset_gnt: got %b required 1", trans_gnt); end
  endtask

  task automatic test_read_lane();
    do_reset();
    trans_req = 1; trans_we = 0; trans_id = 2; trans_add = 32'h104;
    #2;
    nvec++;
    if (trans_gnt !== 1'b1) begin nfail++; $display("FAIL lane_gnt: got %b required 1", trans_gnt); end
    step(); idle();
    r_valid = 1; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 0; r_last = 1; r_id = 2;
    #2;
    nvec++;
    if ({r_ready, b_ready} !== 2'b10) begin nfail++; $display("FAIL lane_ready: got %b required 10", {r_ready, b_ready}); end
    step(); idle();
    nvec++;
    if ({per_valid, per_id, per_rdata, per_opc, xv, busy} !== {1'b1, 5'b00100, 32'hAAAA_BBBB, 1'b0, 4'b0, 1'b0}) begin
      nfail++; $display("FAIL lane_high: got v=%b id=%b d=%h opc=%b xv=%b busy=%b required 1 00100 aaaabbbb 0 0000 0",
                        per_valid, per_id, per_rdata, per_opc, xv, busy);
    end
    trans_req = 1; trans_we = 0; trans_id = 1; trans_add = 32'h100;
    step(); idle();
    r_valid = 1; r_data = 64'h0123_4567_89AB_CDEF; r_last = 0; r_id = 1;
    step(); idle();
    nvec++;
    if ({per_valid, per_id, per_rdata, busy} !== {1'b1, 5'b00010, 32'h89AB_CDEF, 1'b1}) begin
      nfail++; $display("FAIL lane_low_nolast: got v=%b id=%b d=%h busy=%b required 1 00010 89abcdef 1",
                        per_valid, per_id, per_rdata, busy);
    end
    step();
    nvec++;
    if (per_valid !== 1'b0) begin nfail++; $display("FAIL pulse_width: got %b required 0", per_valid); end
  endtask

  task automatic test_arbitration();
    do_reset();
    trans_req = 1; trans_we = 1; trans_id = 1; step();
    trans_we = 0; trans_id = 0; step(); idle();
    r_valid = 1; r_id = 0; r_last = 1; r_data = 64'h1111_2222_3333_4444;
    b_valid = 1; b_id = 1; b_resp = 2'b00;
    #2;
    nvec++;
    if ({r_ready, b_ready} !== 2'b10) begin nfail++; $display("FAIL arb_first: got %b required 10", {r_ready, b_ready}); end
    step();
    r_valid = 0;
    #2;
    nvec++;
    if ({r_ready, b_ready, per_valid, per_id, per_rdata} !== {2'b01, 1'b1, 5'b00001, 32'h3333_4444}) begin
      nfail++; $display("FAIL arb_second: got rdy=%b v=%b id=%b d=%h required 01 1 00001 33334444",
                        {r_ready, b_ready}, per_valid, per_id, per_rdata);
    end
    step(); idle();
    nvec++;
    if ({per_valid, per_opc, per_id, per_rdata} !== {1'b1, 1'b0, 5'b00010, 32'h1}) begin
      nfail++; $display("FAIL arb_b_rsp: got v=%b opc=%b id=%b d=%h required 1 0 00010 1",
                        per_valid, per_opc, per_id, per_rdata);
    end
    trans_req = 1; trans_we = 1; trans_id = 1; step();
    trans_we = 0; trans_id = 0; step(); idle();
    r_valid = 1; r_id = 0; r_last = 1; b_valid = 1; b_id = 1;
    #2;
    nvec++;
    if ({r_ready, b_ready} !== 2'b10) begin nfail++; $display("FAIL arb_state_prio_r: got %b required 10", {r_ready, b_ready}); end
    step();
    #2;
    nvec++;
    if ({r_ready, b_ready} !== 2'b01) begin nfail++; $display("FAIL arb_alternate: got %b required 01", {r_ready, b_ready}); end
    step(); idle();
  endtask

  task automatic test_error_resp();
    do_reset();
    trans_req = 1; trans_we = 1; trans_id = 3; step(); idle();
    b_valid = 1; b_id = 3; b_resp = 2'b10;
    step(); idle();
    nvec++;
    if ({per_valid, per_opc, per_id, per_rdata, xv, xs} !== {1'b1, 1'b1, 5'b01000, 32'h0, 4'b1000, 4'b1000}) begin
      nfail++; $display("FAIL slverr: got v=%b opc=%b id=%b d=%h xv=%b xs=%b required 1 1 01000 0 1000 1000",
                        per_valid, per_opc, per_id, per_rdata, xv, xs);
    end
    step();
    nvec++;
    if ({per_valid, xv, xs} !== 9'b0) begin nfail++; $display("FAIL slverr_once: got %b required 0", {per_valid, xv, xs}); end
    trans_req = 1; trans_we = 0; trans_id = 2; trans_add = 0; step(); idle();
    r_valid = 1; r_id = 2; r_last = 1; r_resp = 2'b11; r_data = 64'h5555_6666_7777_8888;
    step(); idle();
    nvec++;
    if ({per_valid, per_opc, per_rdata, xv, xs} !== {1'b1, 1'b1, 32'h7777_8888, 8'b0}) begin
      nfail++; $display("FAIL decerr: got v=%b opc=%b d=%h xv=%b xs=%b required 1 1 77778888 0000 0000",
                        per_valid, per_opc, per_rdata, xv, xs);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    b_valid = 1; b_id = 0; b_resp = 0;
    #2;
    nvec++;
    if (b_ready !== 1'b1) begin nfail++; $display("FAIL unexp_consumed: got %b required 1", b_ready); end
    step(); idle();
    nvec++;
    if ({per_valid, unexp} !== 2'b01) begin nfail++; $display("FAIL unexp_set: got v,u=%b required 01", {per_valid, unexp}); end
    repeat (5) step();
    nvec++;
    if (unexp !== 1'b1) begin nfail++; $display("FAIL unexp_sticky: got %b required 1", unexp); end
    do_reset();
    trans_req = 1; trans_we = 0; trans_id = 2; step(); idle();
    b_valid = 1; b_id = 2;
    step(); idle();
    nvec++;
    if ({per_valid, unexp, busy} !== 3'b011) begin
      nfail++; $display("FAIL dir_mismatch: got v,u,busy=%b required 011", {per_valid, unexp, busy});
    end
  endtask

  task automatic test_gnt_collision();
    do_reset();
    trans_req = 1; trans_we = 0; trans_id = 1; step(); idle();
    trans_req = 1; trans_we = 0; trans_id = 1;
    r_valid = 1; r_id = 1; r_last = 1;
    #2;
    nvec++;
    if ({trans_gnt, r_ready} !== 2'b01) begin nfail++; $display("FAIL collide_gnt: got gnt,rr=%b required 01", {trans_gnt, r_ready}); end
    step(); idle();
    nvec++;
    if ({per_valid, busy} !== 2'b10) begin nfail++; $display("FAIL collide_ignored: got v,busy=%b required 10", {per_valid, busy}); end
    trans_req = 1; trans_we = 1; trans_id = 1;
    #2;
    nvec++;
    if (trans_gnt !== 1'b1) begin nfail++; $display("FAIL retry_gnt: got %b required 1", trans_gnt); end
    step(); idle();
    trans_req = 1; trans_we = 0; trans_id = 2;
    b_valid = 1; b_id = 1;
    step(); idle();
    nvec++;
    if ({per_valid, per_id, per_rdata, busy} !== {1'b1, 5'b00010, 32'h1, 1'b1}) begin
      nfail++; $display("FAIL diff_id_both: got v=%b id=%b d=%h busy=%b required 1 00010 1 1",
                        per_valid, per_id, per_rdata, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    trans_req = 1; trans_we = 0; trans_id = 2; step(); idle();
    rst_n = 0;
    #1;
    nvec++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL async_clear: got %b required 0", busy); end
    @(negedge clk); rst_n = 1; step();
    r_valid = 1; r_id = 2; r_last = 1;
    step(); idle();
    nvec++;
    if ({per_valid, unexp} !== 2'b01) begin nfail++; $display("FAIL stale_after_reset: got v,u=%b required 01", {per_valid, unexp}); end
  endtask

  task automatic test_random();
    int rd_ids[$];
    int wr_ids[$];
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rd_ids.delete(); wr_ids.delete();
      for (int i = 0; i < NB_CORES; i++) begin
        if (m_pend[i]) begin
          if (m_we[i]) wr_ids.push_back(i);
          else rd_ids.push_back(i);
        end
      end
      trans_req = ($urandom_range(0, 2) == 0);
      trans_id  = 3'($urandom_range(0, NB_CORES - 1));
      trans_we  = 1'($urandom);
      trans_add = $urandom;
      r_valid = 0; b_valid = 0;
      if (rd_ids.size() > 0 && $urandom_range(0, 9) < 6) begin
        r_valid = 1; r_id = 3'(rd_ids[$urandom_range(0, rd_ids.size() - 1)]);
      end else if (cyc > 450 && $urandom_range(0, 19) == 0) begin
        r_valid = 1; r_id = 3'($urandom_range(0, NB_CORES - 1));
      end
      if (wr_ids.size() > 0 && $urandom_range(0, 9) < 6) begin
        b_valid = 1; b_id = 3'(wr_ids[$urandom_range(0, wr_ids.size() - 1)]);
      end else if (cyc > 450 && $urandom_range(0, 19) == 0) begin
        b_valid = 1; b_id = 3'($urandom_range(0, NB_CORES - 1));
      end
      r_last = ($urandom_range(0, 2) != 0);
      r_resp = 2'($urandom);
      b_resp = 2'($urandom);
      r_data = {$urandom, $urandom};
      predict();
      #2;
      nvec++;
      if ({r_ready, b_ready, trans_gnt} !== {e_rr, e_br, e_gnt}) begin
        nfail++; $display("FAIL rand_comb @%0d: got rr,br,gnt=%b required %b", cyc,
                          {r_ready, b_ready, trans_gnt}, {e_rr, e_br, e_gnt});
      end
      commit();
      nvec++;
      if ({per_valid, per_opc, per_id, per_rdata, xv, xs, unexp, busy} !==
          {e_valid, e_opc, e_id, e_rdata, e_xv, e_xv, m_unexp, |m_pend}) begin
        nfail++; $display("FAIL rand_rsp @%0d: got v=%b opc=%b id=%b d=%h xv=%b xs=%b u=%b busy=%b required %b %b %b %h %b %b %b %b",
                          cyc, per_valid, per_opc, per_id, per_rdata, xv, xs, unexp, busy,
                          e_valid, e_opc, e_id, e_rdata, e_xv, e_xv, m_unexp, |m_pend);
      end
    end
    idle();
  endtask

`ifdef PER2AXI_RES_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    seen = -1;
    do_reset();
    trans_req = 1; trans_we = 0; trans_id = 2; trans_add = 0; step(); idle();
    for (int c = 1; c <= 20 && seen < 0; c++) begin
      step();
      if (per_valid === 1'b1) begin
        seen = c;
        nvec++;
        if ({per_opc, per_id, per_rdata, xv, xs} !== {1'b1, 5'b00100, 32'h0, 4'b0100, 4'b0100}) begin
          nfail++; $display("FAIL timeout_rsp: got opc=%b id=%b d=%h xv=%b xs=%b required 1 00100 0 0100 0100",
                            per_opc, per_id, per_rdata, xv, xs);
        end
      end
    end
    nvec++;
    if (seen < 8 || seen > 10) begin nfail++; $display("FAIL timeout_latency: got %0d required 8..10", seen); end
    nvec++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL timeout_busy: got %b required 0", busy); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_read_lane();
    test_arbitration();
    test_error_resp();
    test_unexpected();
    test_gnt_collision();
    test_reset_mid();
`ifdef PER2AXI_RES_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
